// File: rtl/jtag_host_seq_if.sv
// jtag_host_seq_if: request/response handshake between a debug front end and the JTAG host sequencer.
interface jtag_host_seq_if #(
  parameter int unsigned MaxLen = 64,
  parameter int unsigned LenW   = $clog2(MaxLen + 1)
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [LenW-1:0]   req_len;
  logic [MaxLen-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [MaxLen-1:0] rsp_data;
  logic              busy;
  modport master (
    output req_valid, req_op, req_len, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy
  );
  modport slave (
    input  req_valid, req_op, req_len, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/jtag_host_seq.sv
// jtag_host_seq: turns DR/IR/TLR scan requests into TCK/TMS/TDI pin activity and returns captured TDO.
module jtag_host_seq #(
  parameter int unsigned TckDiv = 2,
  parameter int unsigned MaxLen = 64,
  parameter int unsigned LenW   = $clog2(MaxLen + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  jtag_host_seq_if.slave bus,
  output logic jtag_tck_o,
  output logic jtag_tms_o,
  output logic jtag_tdi_o,
  output logic jtag_trst_no,
  input  logic jtag_tdo_i
);
  localparam int unsigned CntW = LenW < 3 ? 3 : LenW;
  localparam int unsigned DivW = TckDiv > 1 ? $clog2(TckDiv) : 1;
  typedef enum logic [3:0] {IDLE, TLR, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RTI, RESP} state_e;
  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, last_q, last_d;
  logic [DivW-1:0] div_q, div_d;
  logic [MaxLen-1:0] data_q, data_d, mask_q, mask_d, rsp_q, rsp_d;
  logic [LenW-1:0] len_c;
  logic tck_q, tck_d, start_q, start_d, tms_q, tms_d, tdi_q, tdi_d, trst_q, trst_d;
  logic ready_q, ready_d, valid_q, valid_d, busy_q, busy_d, tick, enter;
  always_comb begin
    len_c = bus.req_len == '0 ? LenW'(1) : bus.req_len > LenW'(MaxLen) ? LenW'(MaxLen) : bus.req_len;
    tick = div_q == DivW'(TckDiv - 1);
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    div_d = div_q;
    data_d = data_q;
    mask_d = mask_q;
    rsp_d = rsp_q;
    tck_d = tck_q;
    start_d = start_q;
    tms_d = tms_q;
    tdi_d = tdi_q;
    trst_d = trst_q | (state_q == IDLE);
    enter = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req_valid && ready_q) begin
        state_d = bus.req_op == 2'd0 ? SEL_DR : bus.req_op == 2'd1 ? SEL_IR : TLR;
        cnt_d = '0;
        last_d = CntW'(len_c) - CntW'(1);
        data_d = bus.req_data;
        mask_d = MaxLen'(1);
        rsp_d = '0;
        start_d = 1'b1;
        div_d = '0;
      end
    end else if (state_q == RESP) begin
      if (bus.rsp_ready) state_d = IDLE;
    end else if (start_q) begin
      start_d = 1'b0;
      div_d = '0;
      enter = 1'b1;
    end else if (!tick) begin
      div_d = div_q + DivW'(1);
    end else begin
      div_d = '0;
      if (!tck_q) begin
        tck_d = 1'b1;
        if (state_q == SHIFT && jtag_tdo_i) rsp_d = rsp_q | mask_q;
      end else begin
        // falling TCK: advance one TAP step and present its TMS/TDI for the coming period
        tck_d = 1'b0;
        enter = 1'b1;
        cnt_d = cnt_q + CntW'(1);
        case (state_q)
          TLR:     if (cnt_q == CntW'(4)) begin state_d = RTI; cnt_d = '0; end
          RTI:     state_d = RESP;
          SEL_IR:  state_d = SEL_DR;
          SEL_DR:  begin state_d = CAPTURE; cnt_d = '0; end
          CAPTURE: if (cnt_q == CntW'(1)) begin state_d = SHIFT; cnt_d = '0; end
          SHIFT:   if (cnt_q == last_q) state_d = EXIT1;
                   else begin data_d = data_q >> 1; mask_d = mask_q << 1; end
          EXIT1:   state_d = UPDATE;
          UPDATE:  state_d = RESP;
          default: state_d = IDLE;
        endcase
      end
    end
    if (enter) begin
      tms_d = state_d == SHIFT ? cnt_d == last_q : state_d inside {TLR, SEL_DR, SEL_IR, EXIT1};
      tdi_d = (state_d == SHIFT) && data_d[0];
      trst_d = state_d != TLR;
    end
    ready_d = state_d == IDLE;
    valid_d = state_d == RESP;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= '0;
      div_q <= '0;
      data_q <= '0;
      mask_q <= '0;
      rsp_q <= '0;
      tck_q <= 1'b0;
      start_q <= 1'b0;
      tms_q <= 1'b0;
      tdi_q <= 1'b0;
      trst_q <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      div_q <= div_d;
      data_q <= data_d;
      mask_q <= mask_d;
      rsp_q <= rsp_d;
      tck_q <= tck_d;
      start_q <= start_d;
      tms_q <= tms_d;
      tdi_q <= tdi_d;
      trst_q <= trst_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
    end
  end
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_data = rsp_q;
  assign bus.busy = busy_q;
  assign jtag_tck_o = tck_q;
  assign jtag_tms_o = tms_q;
  assign jtag_tdi_o = tdi_q;
  assign jtag_trst_no = trst_q;
endmodule

// File: tb/tb_jtag_host_seq.sv
// tb_jtag_host_seq: scoreboard bench for jtag_host_seq with pin-level TMS/TDI/TRST capture.
module tb_jtag_host_seq;
  localparam int ML = 64;
  logic clk = 0, rst_n = 0, tdo_one = 0;
  logic tck, tms, tdi, trst_n, tdo;
  always #5 clk = ~clk;
  jtag_host_seq_if #(.MaxLen(ML)) bus();
  jtag_host_seq #(.TckDiv(2), .MaxLen(ML)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .jtag_tck_o(tck), .jtag_tms_o(tms), .jtag_tdi_o(tdi), .jtag_trst_no(trst_n), .jtag_tdo_i(tdo)
  );
  assign tdo = tdo_one | tdi;
  int n_tests = 0, n_fail = 0, cyc = 0, acc = 0, n_tck = 0, n_trst = 0, exp_n = 0, exp_lat = 0, exp_trst = 0;
  time t0 = 0, per = 0;
  logic tck_prev = 0, busy_prev = 0;
  logic [127:0] obs_tms, obs_tdi, exp_tms, exp_tdi;
  logic [ML-1:0] sb_q[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.busy && !busy_prev) begin
      n_tck = 0; n_trst = 0; obs_tms = '0; obs_tdi = '0;
    end
    if (tck && !tck_prev) begin
      if (n_tck == 0) t0 = $time;
      if (n_tck == 1) per = ($time - t0) / 10;
      if (n_tck < 128) begin obs_tms[n_tck] = tms; obs_tdi[n_tck] = tdi; end
      n_trst += int'(!trst_n);
      n_tck++;
    end
    tck_prev = tck;
    busy_prev = bus.busy;
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [1:0] op, input int len, input logic [ML-1:0] data);
    int l, off;
    logic [ML-1:0] m, one;
    one = 1;
    l = len == 0 ? 1 : len > ML ? ML : len;
    m = (l >= ML) ? '1 : (one << l) - one;
    exp_tms = '0;
    exp_tdi = '0;
    if (op >= 2) begin
      exp_tms = 128'h1f; exp_n = 6; exp_trst = 5;
      sb_q.push_back('0);
    end else begin
      off = op == 1 ? 4 : 3;
      exp_tms[0] = 1'b1;
      if (op == 1) exp_tms[1] = 1'b1;
      exp_tms[off + l - 1] = 1'b1;
      exp_tms[off + l] = 1'b1;
      exp_n = l + off + 2;
      exp_trst = 0;
      exp_tdi = {64'b0, data & m} << off;
      sb_q.push_back(tdo_one ? m : data & m);
    end
    exp_lat = exp_n * 4 + 1;
    for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
    chk("req_ready", bus.req_ready, 1);
    bus.req_op = op;
    bus.req_len = 7'(len);
    bus.req_data = data;
    bus.req_valid = 1;
    @(posedge clk);
    #1 acc = cyc;
    bus.req_valid = 0;
  endtask
  task automatic get_rsp(input string tag, input int hold);
    logic [ML-1:0] d;
    logic ok;
    for (int i = 0; i < 1000 && !bus.rsp_valid; i++) @(negedge clk);
    chk({tag, " valid"}, bus.rsp_valid, 1);
    if (!bus.rsp_valid) begin sb_q.delete(); return; end
    chk({tag, " latency"}, cyc - acc, exp_lat);
    if (sb_q.size() == 0) chk({tag, " sb_empty"}, 1, 0);
    else chk({tag, " data"}, bus.rsp_data, sb_q.pop_front());
    chk({tag, " n_tck"}, n_tck, exp_n);
    chk({tag, " tms"}, obs_tms, exp_tms);
    chk({tag, " tdi"}, obs_tdi, exp_tdi);
    chk({tag, " trst_low"}, n_trst, exp_trst);
    ok = 1;
    d = bus.rsp_data;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      ok &= bus.rsp_valid && bus.rsp_data == d && !tck && !bus.req_ready;
    end
    if (hold > 0) chk({tag, " hold"}, ok, 1);
    bus.rsp_ready = 1;
    @(posedge clk);
    #1 bus.rsp_ready = 0;
    chk({tag, " after"}, {bus.req_ready, bus.rsp_valid, bus.busy}, 3'b100);
  endtask
  initial begin
    bus.req_valid = 0; bus.req_op = 0; bus.req_len = 0; bus.req_data = 0; bus.rsp_ready = 0;
    repeat (3) @(negedge clk);
    chk("reset", {bus.req_ready, bus.rsp_valid, bus.busy, tck, tms, tdi, trst_n, bus.rsp_data}, 0);
    rst_n = 1;
    @(posedge clk);
    #1 chk("release", {bus.req_ready, trst_n}, 2'b11);
    @(negedge clk);
    send(0, 8, 64'hA5);
    get_rsp("dr8", 0);
    chk("tck_period", per, 4);
    tdo_one = 1;
    send(1, 5, 64'h11);
    get_rsp("ir5", 0);
    tdo_one = 0;
    send(2, 8, 64'hFF);
    get_rsp("tlr", 0);
    send(0, 12, 64'h5A3);
    get_rsp("dr_after_tlr", 0);
    send(0, 16, 64'hBEEF);
    get_rsp("hold", 20);
    send(0, 0, '1);
    get_rsp("len0", 0);
    send(0, ML + 5, 64'hDEADBEEF_01234567);
    get_rsp("len_max", 0);
    send(3, 3, 64'h7);
    get_rsp("op3", 0);
    for (int r = 0; r < 4; r++) begin
      tdo_one = 1'($urandom_range(0, 1));
      send(2'($urandom_range(0, 1)), $urandom_range(1, ML), {$urandom, $urandom});
      get_rsp("rand", 0);
    end
    tdo_one = 0;
    send(0, ML, 64'hDEADBEEF_01234567);
    repeat (30) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("rst_mid", {bus.req_ready, bus.rsp_valid, bus.busy, tck, tms, tdi, trst_n, bus.rsp_data}, 0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    send(2, 1, 0);
    get_rsp("post_rst_tlr", 0);
    send(0, 32, 64'h0123_4567_89AB);
    get_rsp("post_rst_dr", 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
